// File: rtl/turbo_pkt_dispatch.sv
// Packet-atomic round-robin dispatcher: hands whole packets of bus beats to
// idle, ready turbo lanes and logs the dispatch order for the output mux.
//
// Ports:
//   clk_st, rst_n        clock, async active-low reset
//   in_en / in_ready     upstream beat handshake
//   dec_en               per-lane beat enable (one-hot or zero)
//   dec_ready, dec_done  per-lane ready and end-of-packet-drained pulse
//   ord_idx, ord_valid   order FIFO head (show-ahead)
//   ord_pop              output mux consumed the head entry
//   busy                 lane holds an undrained packet
//   pkt_cnt              packets dispatched since reset (wraps)
module turbo_pkt_dispatch #(
  parameter int NUM_TURBO     = 2,
  parameter int BEATS_PER_PKT = 25,
  parameter int IDXW          = 4,
  parameter int ORD_DEPTH     = 16
) (
  input  logic                 clk_st,
  input  logic                 rst_n,
  input  logic                 in_en,
  output logic                 in_ready,
  output logic [NUM_TURBO-1:0] dec_en,
  input  logic [NUM_TURBO-1:0] dec_ready,
  input  logic [NUM_TURBO-1:0] dec_done,
  output logic [IDXW-1:0]      ord_idx,
  output logic                 ord_valid,
  input  logic                 ord_pop,
  output logic [NUM_TURBO-1:0] busy,
  output logic [15:0]          pkt_cnt
);

  localparam int PW = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
  localparam int CW = $clog2(ORD_DEPTH + 1);
  localparam int BW = $clog2(BEATS_PER_PKT);

  typedef enum logic {IDLE, XFER} state_e;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      grant_q, grant_d;
  logic [IDXW-1:0]      last_q, last_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [NUM_TURBO-1:0] busy_q, busy_d;
  logic [15:0]          pkt_q, pkt_d;
  logic [IDXW-1:0]      mem_q [ORD_DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        cnt_q;

  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 found;
  logic [IDXW-1:0]      pick;
  logic [NUM_TURBO-1:0] cand;
  logic [NUM_TURBO-1:0] gsel;

  assign full = (cnt_q == CW'(ORD_DEPTH));
  assign pop  = ord_pop & (cnt_q != '0);
  assign cand = ~busy_q & dec_ready & {NUM_TURBO{~full}};

  always_comb begin : gsel_dec
    gsel = '0;
    for (int i = 0; i < NUM_TURBO; i++) begin
      gsel[i] = (grant_q == IDXW'(i));
    end
  end

  // Search starts one past the last granted lane so every lane gets a turn.
  always_comb begin : arb
    int j;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 1; k <= NUM_TURBO; k++) begin
      j = (int'(last_q) + k) % NUM_TURBO;
      if (!found && cand[j]) begin
        found = 1'b1;
        pick  = IDXW'(j);
      end
    end
  end

  assign in_ready = (state_q == XFER) & |(gsel & dec_ready);
  assign accept   = in_en & in_ready;
  assign dec_en   = accept ? gsel : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          if (beat_q == BW'(BEATS_PER_PKT - 1)) begin
            beat_d  = '0;
            push    = 1'b1;
            last_d  = grant_q;
            pkt_d   = pkt_q + 16'd1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
    endcase
  end

  // A new packet landing on a lane outranks a stale done pulse.
  assign busy_d = (busy_q & ~dec_done) | (push ? gsel : '0);

  always_ff @(posedge clk_st or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDXW'(NUM_TURBO - 1);
      beat_q  <= '0;
      busy_q  <= '0;
      pkt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      pkt_q   <= pkt_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      if (push && !pop) cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_st) begin
    if (push) mem_q[wr_q] <= grant_q;
  end

  assign ord_valid = (cnt_q != '0);
  assign ord_idx   = ord_valid ? mem_q[rd_q] : '0;
  assign busy      = busy_q;
  assign pkt_cnt   = pkt_q;

endmodule
